// File: rtl/llc_mem_bridge_pkg.sv
// Shared constants, types and bridge FSM state for the LLC-to-memory bridge.
// Default geometry: 128-bit lines carried as two 64-bit beats on a 32-bit byte-address bus.
package llc_mem_bridge_pkg;

  localparam int unsigned LLC_ADDR_BITS   = 32;
  localparam int unsigned LLC_LINE_BITS   = 128;
  localparam int unsigned LLC_WORD_BITS   = 64;
  localparam int unsigned LLC_OFFSET_BITS = 4;
  localparam int unsigned LLC_BEATS       = LLC_LINE_BITS / LLC_WORD_BITS;
  localparam int unsigned LLC_BEAT_BITS   = $clog2(LLC_BEATS);

  typedef logic [LLC_ADDR_BITS-LLC_OFFSET_BITS-1:0] line_addr_t;
  typedef logic [LLC_LINE_BITS-1:0]                 line_t;
  typedef logic [LLC_WORD_BITS-1:0]                 word_t;
  typedef logic                                     hprot_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    RD_RSP,
    WR_CMD,
    WR_DATA
  } llc_mem_bridge_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/llc_mem_bridge_serdes.sv
// Line register plus beat counter: inserts read beats into the line (beat 0 = LSBs)
// and presents the current beat's word for writeback serialisation.
module llc_mem_bridge_serdes
  import llc_mem_bridge_pkg::*;
#(
  parameter int unsigned LINE_BITS = LLC_LINE_BITS,
  parameter int unsigned WORD_BITS = LLC_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 insert,
  input  logic [WORD_BITS-1:0] insert_word,
  input  logic                 advance,
  output logic [LINE_BITS-1:0] line,
  output logic [WORD_BITS-1:0] word,
  output logic                 last
);

  localparam int unsigned BEATS     = LINE_BITS / WORD_BITS;
  localparam int unsigned BEAT_BITS = $clog2(BEATS);

  logic [LINE_BITS-1:0] line_q;
  logic [BEAT_BITS-1:0] beat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      beat_q <= '0;
    end else if (load) begin
      line_q <= load_line;
      beat_q <= '0;
    end else if (insert) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (beat_q == BEAT_BITS'(i)) line_q[i*WORD_BITS +: WORD_BITS] <= insert_word;
      end
      beat_q <= beat_q + BEAT_BITS'(1);
    end else if (advance) begin
      beat_q <= beat_q + BEAT_BITS'(1);
    end
  end

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat_q == BEAT_BITS'(i)) word = line_q[i*WORD_BITS +: WORD_BITS];
    end
  end

  assign line = line_q;
  assign last = (beat_q == BEAT_BITS'(BEATS - 1));

endmodule

// File: rtl/llc_mem_bridge.sv
// LLC-to-memory bridge: one line-granular read or writeback in flight, serialised into word beats.
// Optional statistics outputs are built when LLC_MEM_BRIDGE_STATS_EN is defined.
module llc_mem_bridge
  import llc_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = LLC_ADDR_BITS,
  parameter int unsigned LINE_BITS   = LLC_LINE_BITS,
  parameter int unsigned WORD_BITS   = LLC_WORD_BITS,
  parameter int unsigned OFFSET_BITS = LLC_OFFSET_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            llc_mem_req_valid,
  output logic                            llc_mem_req_ready,
  input  logic                            llc_mem_req_hwrite,
  input  logic [ADDR_BITS-OFFSET_BITS-1:0] llc_mem_req_addr,
  input  logic                            llc_mem_req_hprot,
  input  logic [LINE_BITS-1:0]            llc_mem_req_line,
  output logic                            llc_mem_rsp_valid,
  input  logic                            llc_mem_rsp_ready,
  output logic [LINE_BITS-1:0]            llc_mem_rsp_line,
  output logic                            mem_cmd_valid,
  input  logic                            mem_cmd_ready,
  output logic                            mem_cmd_write,
  output logic [ADDR_BITS-1:0]            mem_cmd_addr,
  output logic                            mem_cmd_hprot,
  output logic [7:0]                      mem_cmd_len,
  output logic                            mem_wdata_valid,
  input  logic                            mem_wdata_ready,
  output logic [WORD_BITS-1:0]            mem_wdata,
  output logic                            mem_wdata_last,
  input  logic                            mem_rdata_valid,
  output logic                            mem_rdata_ready,
  input  logic [WORD_BITS-1:0]            mem_rdata
`ifdef LLC_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]                     stat_rd_cnt,
  output logic [31:0]                     stat_wr_cnt,
  output logic [15:0]                     stat_rd_lat_max
`endif
);

  localparam int unsigned BEATS = LINE_BITS / WORD_BITS;

  llc_mem_bridge_state_t state_q, state_d;

  logic                             hwrite_q;
  logic                             hprot_q;
  logic [ADDR_BITS-OFFSET_BITS-1:0] addr_q;

  logic req_fire, rdata_fire, wdata_fire;
  logic sd_last;

  assign req_fire   = llc_mem_req_valid & llc_mem_req_ready;
  assign rdata_fire = mem_rdata_valid & mem_rdata_ready;
  assign wdata_fire = mem_wdata_valid & mem_wdata_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hwrite_q <= 1'b0;
      hprot_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        hwrite_q <= llc_mem_req_hwrite;
        hprot_q  <= llc_mem_req_hprot;
        addr_q   <= llc_mem_req_addr;
      end
    end
  end

  // Ready is qualified by rst so nothing is offered while reset is asserted.
  always_comb begin
    state_d           = state_q;
    llc_mem_req_ready = 1'b0;
    mem_cmd_valid     = 1'b0;
    mem_wdata_valid   = 1'b0;
    mem_rdata_ready   = 1'b0;
    llc_mem_rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        llc_mem_req_ready = rst;
        if (llc_mem_req_valid && rst) state_d = llc_mem_req_hwrite ? WR_CMD : RD_CMD;
      end
      RD_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        mem_rdata_ready = 1'b1;
        if (mem_rdata_valid && sd_last) state_d = RD_RSP;
      end
      RD_RSP: begin
        llc_mem_rsp_valid = 1'b1;
        if (llc_mem_rsp_ready) state_d = IDLE;
      end
      WR_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        mem_wdata_valid = 1'b1;
        if (mem_wdata_ready && sd_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  llc_mem_bridge_serdes #(
    .LINE_BITS (LINE_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_serdes (
    .clk         (clk),
    .rst         (rst),
    .load        (req_fire),
    .load_line   (llc_mem_req_line),
    .insert      (rdata_fire),
    .insert_word (mem_rdata),
    .advance     (wdata_fire),
    .line        (llc_mem_rsp_line),
    .word        (mem_wdata),
    .last        (sd_last)
  );

  assign mem_cmd_write  = hwrite_q;
  assign mem_cmd_addr   = {addr_q, {OFFSET_BITS{1'b0}}};
  assign mem_cmd_hprot  = hprot_q;
  assign mem_cmd_len    = 8'(BEATS - 1);
  assign mem_wdata_last = mem_wdata_valid & sd_last;

`ifdef LLC_MEM_BRIDGE_STATS_EN
  logic        rsp_fire;
  logic [15:0] lat_cnt;
  logic [15:0] lat_now;
  logic        in_read;

  assign rsp_fire = llc_mem_rsp_valid & llc_mem_rsp_ready;
  assign in_read  = (state_q == RD_CMD) || (state_q == RD_DATA) || (state_q == RD_RSP);
  // Latency counts clock edges from the accepting edge up to and including the rsp-fire edge.
  assign lat_now  = sat_inc16(lat_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rd_cnt     <= '0;
      stat_wr_cnt     <= '0;
      stat_rd_lat_max <= '0;
      lat_cnt         <= '0;
    end else begin
      if (req_fire) begin
        lat_cnt <= '0;
        if (llc_mem_req_hwrite) stat_wr_cnt <= sat_inc32(stat_wr_cnt);
        else                    stat_rd_cnt <= sat_inc32(stat_rd_cnt);
      end else if (in_read) begin
        lat_cnt <= lat_now;
      end
      if (rsp_fire && (lat_now > stat_rd_lat_max)) stat_rd_lat_max <= lat_now;
    end
  end
`endif

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Directed bench for llc_mem_bridge with a transaction-level scoreboard and a memory responder.
// Define LLC_MEM_BRIDGE_STATS_EN to also exercise the statistics outputs.
module tb_llc_mem_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         llc_mem_req_valid, llc_mem_req_ready, llc_mem_req_hwrite, llc_mem_req_hprot;
  logic [27:0]  llc_mem_req_addr;
  logic [127:0] llc_mem_req_line;
  logic         llc_mem_rsp_valid, llc_mem_rsp_ready;
  logic [127:0] llc_mem_rsp_line;
  logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_write, mem_cmd_hprot;
  logic [31:0]  mem_cmd_addr;
  logic [7:0]   mem_cmd_len;
  logic         mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
  logic [63:0]  mem_wdata;
  logic         mem_rdata_valid, mem_rdata_ready;
  logic [63:0]  mem_rdata;
`ifdef LLC_MEM_BRIDGE_STATS_EN
  logic [31:0]  stat_rd_cnt, stat_wr_cnt;
  logic [15:0]  stat_rd_lat_max;
`endif

  llc_mem_bridge dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_hwrite(llc_mem_req_hwrite), .llc_mem_req_addr(llc_mem_req_addr),
    .llc_mem_req_hprot(llc_mem_req_hprot), .llc_mem_req_line(llc_mem_req_line),
    .llc_mem_rsp_valid(llc_mem_rsp_valid), .llc_mem_rsp_ready(llc_mem_rsp_ready),
    .llc_mem_rsp_line(llc_mem_rsp_line),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_hprot(mem_cmd_hprot), .mem_cmd_len(mem_cmd_len),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready), .mem_rdata(mem_rdata)
`ifdef LLC_MEM_BRIDGE_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_rd_lat_max(stat_rd_lat_max)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder configuration and state
  int          cmd_stall = 0, rd_gap = 0, rsp_stall = 0;
  int          cmd_wait = 0, gap_cnt = 0, rsp_wait = 0;
  logic [63:0] rd_src[$];
  logic [63:0] mem_q[$];
  bit          s_cmd_fire, s_cmd_wr, s_rd_fire;

  // Scoreboard state
  logic [41:0]  exp_cmd_q[$];
  logic [64:0]  exp_w_q[$];
  logic [127:0] exp_rsp_q[$];
  logic [63:0]  rb[$];
  logic [64:0]  w_log[$];
  int unsigned  acc_hist[$];
  int unsigned  acc_cyc = 0, wr_done_cyc = 0;
  int unsigned  last_lat = 0, lat_max = 0;
  int           done_cnt = 0, rsp_cnt = 0, rd_fire_total = 0, rd_acc = 0, wr_acc = 0;
  logic [31:0]  last_cmd_addr;
  logic [7:0]   last_cmd_len;
  logic         last_cmd_write;
  logic [127:0] last_rsp;
  logic         rdy_pending = 1'b0, ready_after_wr = 1'b0;
  logic         p_cmd_hold = 1'b0, p_rsp_hold = 1'b0;
  logic [41:0]  p_cmd;
  logic [127:0] p_rsp;

  // Responder: inputs change 1 time unit after the active edge
  initial begin
    mem_cmd_ready = 0; mem_rdata_valid = 0; mem_rdata = '0;
    llc_mem_rsp_ready = 0; mem_wdata_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mem_q.delete();
        mem_cmd_ready = 0; mem_rdata_valid = 0; llc_mem_rsp_ready = 0;
        cmd_wait = 0; gap_cnt = 0; rsp_wait = 0;
      end else begin
        if (s_cmd_fire && !s_cmd_wr)
          repeat (2) if (rd_src.size() > 0) mem_q.push_back(rd_src.pop_front());
        if (s_rd_fire) begin
          void'(mem_q.pop_front());
          gap_cnt = 0;
        end
        if (mem_cmd_valid) begin
          if (cmd_wait < cmd_stall) begin mem_cmd_ready = 0; cmd_wait++; end
          else mem_cmd_ready = 1;
        end else begin
          mem_cmd_ready = 0; cmd_wait = 0;
        end
        if (mem_q.size() > 0) begin
          if (gap_cnt < rd_gap) begin mem_rdata_valid = 0; gap_cnt++; end
          else begin mem_rdata_valid = 1; mem_rdata = mem_q[0]; end
        end else mem_rdata_valid = 0;
        if (llc_mem_rsp_valid) begin
          if (rsp_wait < rsp_stall) begin llc_mem_rsp_ready = 0; rsp_wait++; end
          else llc_mem_rsp_ready = 1;
        end else begin
          llc_mem_rsp_ready = 0; rsp_wait = 0;
        end
      end
    end
  end

  // Compare process: on each falling edge, judge the handshakes that fire at the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      s_cmd_fire = 0; s_cmd_wr = 0; s_rd_fire = 0;
      if (!rst) begin
        exp_cmd_q.delete(); exp_w_q.delete(); exp_rsp_q.delete(); rb.delete();
        p_cmd_hold = 0; p_rsp_hold = 0; rdy_pending = 0;
        lat_max = 0; rd_acc = 0; wr_acc = 0;
      end else begin
        if (rdy_pending) begin ready_after_wr = llc_mem_req_ready; rdy_pending = 0; end
        chk("one_phase_active",
            32'(mem_cmd_valid) + 32'(mem_wdata_valid) + 32'(llc_mem_rsp_valid) +
            32'(mem_rdata_ready) + 32'(llc_mem_req_ready) <= 1, 1);
        if (p_cmd_hold)
          chk("cmd_hold", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hprot, mem_cmd_len},
              {1'b1, p_cmd});
        if (p_rsp_hold)
          chk("rsp_hold", {llc_mem_rsp_valid, llc_mem_rsp_line}, {1'b1, p_rsp});
        if (llc_mem_req_valid && llc_mem_req_ready) begin
          exp_cmd_q.push_back({llc_mem_req_hwrite, llc_mem_req_addr, 4'h0, llc_mem_req_hprot, 8'd1});
          if (llc_mem_req_hwrite) begin
            exp_w_q.push_back({1'b0, llc_mem_req_line[63:0]});
            exp_w_q.push_back({1'b1, llc_mem_req_line[127:64]});
            wr_acc++;
          end else rd_acc++;
          acc_cyc = cyc;
          acc_hist.push_back(cyc);
        end
        if (mem_cmd_valid && mem_cmd_ready) begin
          if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
          else chk("cmd_fields", {mem_cmd_write, mem_cmd_addr, mem_cmd_hprot, mem_cmd_len},
                   exp_cmd_q.pop_front());
          s_cmd_fire = 1; s_cmd_wr = mem_cmd_write;
          last_cmd_addr = mem_cmd_addr; last_cmd_len = mem_cmd_len; last_cmd_write = mem_cmd_write;
        end
        if (mem_wdata_valid && mem_wdata_ready) begin
          if (exp_w_q.size() == 0) chk("wdata_unexpected", 1, 0);
          else chk("wdata_beat", {mem_wdata_last, mem_wdata}, exp_w_q.pop_front());
          w_log.push_back({mem_wdata_last, mem_wdata});
          if (mem_wdata_last) begin done_cnt++; wr_done_cyc = cyc; rdy_pending = 1; end
        end
        if (mem_rdata_valid && mem_rdata_ready) begin
          rb.push_back(mem_rdata);
          if (rb.size() == 2) begin exp_rsp_q.push_back({rb[1], rb[0]}); rb.delete(); end
          s_rd_fire = 1; rd_fire_total++;
        end
        if (llc_mem_rsp_valid && llc_mem_rsp_ready) begin
          if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else chk("rsp_line", llc_mem_rsp_line, exp_rsp_q.pop_front());
          last_rsp = llc_mem_rsp_line;
          last_lat = cyc - acc_cyc;
          if (last_lat > lat_max) lat_max = last_lat;
          done_cnt++; rsp_cnt++;
        end
        p_cmd_hold = mem_cmd_valid && !mem_cmd_ready;
        p_cmd      = {mem_cmd_write, mem_cmd_addr, mem_cmd_hprot, mem_cmd_len};
        p_rsp_hold = llc_mem_rsp_valid && !llc_mem_rsp_ready;
        p_rsp      = llc_mem_rsp_line;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with valid still high.
  task automatic req(input logic w, input logic [27:0] a, input logic hp, input logic [127:0] ln);
    llc_mem_req_valid = 1; llc_mem_req_hwrite = w; llc_mem_req_addr = a;
    llc_mem_req_hprot = hp; llc_mem_req_line = ln;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (llc_mem_req_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("req_accept_timeout", 1, 0);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 500; i++) begin
      if (done_cnt >= n) return;
      @(posedge clk); #1;
    end
    chk("done_timeout", 1, 0);
  endtask

  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    llc_mem_req_valid = 0; llc_mem_req_hwrite = 0; llc_mem_req_addr = '0;
    llc_mem_req_hprot = 0; llc_mem_req_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", {mem_cmd_valid, mem_wdata_valid, llc_mem_rsp_valid, mem_rdata_ready,
                       llc_mem_req_ready}, 5'b0);
    chk("rst_rsp_line", llc_mem_rsp_line, 128'h0);
    #2 rst = 1;
    @(negedge clk);
    chk("idle_ready", llc_mem_req_ready, 1);
    chk("idle_cmd_addr", mem_cmd_addr, 32'h0);
    @(posedge clk); #1;

    // 1: read, no backpressure
    rd_src.push_back(64'hA); rd_src.push_back(64'hB);
    base = done_cnt;
    req(0, 28'h0123456, 1, '0); llc_mem_req_valid = 0;
    wait_done(base + 1);
    chk("t1_cmd_addr", last_cmd_addr, 32'h01234560);
    chk("t1_cmd_len", last_cmd_len, 8'd1);
    chk("t1_line", last_rsp, {64'hB, 64'hA});
    chk("t1_latency", last_lat, 4);

    // 2: writeback
    w_log.delete();
    base = done_cnt;
    req(1, 28'h0000ABC, 0, {64'h22, 64'h11}); llc_mem_req_valid = 0;
    wait_done(base + 1);
    repeat (2) @(posedge clk); #1;
    chk("t2_cmd_write", last_cmd_write, 1);
    chk("t2_beat0", w_log[0], {1'b0, 64'h11});
    chk("t2_beat1", w_log[1], {1'b1, 64'h22});
    chk("t2_cycles", wr_done_cyc - acc_cyc, 3);
    chk("t2_ready_next", ready_after_wr, 1);

    // 3: backpressure on every channel
    cmd_stall = 3; rd_gap = 2; rsp_stall = 2;
    rd_src.push_back(64'hDEADBEEF_00000001); rd_src.push_back(64'hCAFEF00D_00000002);
    base = rsp_cnt;
    req(0, 28'hFEDCBA9, 0, '0); llc_mem_req_valid = 0;
    wait_done(done_cnt + 1);
    repeat (4) @(posedge clk); #1;
    chk("t3_line", last_rsp, {64'hCAFEF00D_00000002, 64'hDEADBEEF_00000001});
    chk("t3_single_rsp", rsp_cnt - base, 1);
    chk("t3_cmd_addr", last_cmd_addr, 32'hFEDCBA90);
    cmd_stall = 0; rd_gap = 0; rsp_stall = 0;

    // 4: back-to-back read then write with valid held
    acc_hist.delete();
    rd_src.push_back(64'h5555); rd_src.push_back(64'h6666);
    base = done_cnt;
    req(0, 28'h0000010, 1, '0);
    req(1, 28'h0000020, 1, {64'h88, 64'h77});
    llc_mem_req_valid = 0;
    wait_done(base + 2);
    chk("t4_accept_gap", acc_hist[1] - acc_hist[0], 5);
    chk("t4_line", last_rsp, {64'h6666, 64'h5555});

    // 5: async reset during RD_DATA after beat 0
    rd_src.push_back(64'h1111); rd_src.push_back(64'h2222);
    base = rd_fire_total;
    req(0, 28'h0000030, 0, '0); llc_mem_req_valid = 0;
    for (int i = 0; i < 100 && rd_fire_total <= base; i++) begin @(posedge clk); #1; end
    chk("t5_beat0_seen", rd_fire_total, base + 1);
    #1 rst = 0;
    @(negedge clk);
    chk("t5_rst_valids", {mem_cmd_valid, mem_wdata_valid, llc_mem_rsp_valid, mem_rdata_ready,
                          llc_mem_req_ready}, 5'b0);
    @(posedge clk); #3 rst = 1;
    @(negedge clk);
    chk("t5_idle_ready", llc_mem_req_ready, 1);
    chk("t5_line_cleared", llc_mem_rsp_line, 128'h0);
    @(posedge clk); #1;
    rd_src.delete();
    rd_src.push_back(64'h3333); rd_src.push_back(64'h4444);
    base = rsp_cnt;
    req(0, 28'h0000040, 0, '0); llc_mem_req_valid = 0;
    wait_done(done_cnt + 1);
    chk("t5_line", last_rsp, {64'h4444, 64'h3333});
    chk("t5_single_rsp", rsp_cnt - base, 1);

`ifdef LLC_MEM_BRIDGE_STATS_EN
    // 6: two more reads (one slowed) and two writes since the last reset
    rd_src.push_back(64'h1); rd_src.push_back(64'h2);
    req(0, 28'h0000050, 0, '0); llc_mem_req_valid = 0;
    wait_done(done_cnt + 1);
    cmd_stall = 2; rsp_stall = 1;
    rd_src.push_back(64'h3); rd_src.push_back(64'h4);
    req(0, 28'h0000060, 0, '0); llc_mem_req_valid = 0;
    wait_done(done_cnt + 1);
    chk("t6_slow_latency", last_lat, 7);
    cmd_stall = 0; rsp_stall = 0;
    req(1, 28'h0000070, 0, {64'hB, 64'hA}); llc_mem_req_valid = 0;
    wait_done(done_cnt + 1);
    req(1, 28'h0000080, 1, {64'hD, 64'hC}); llc_mem_req_valid = 0;
    wait_done(done_cnt + 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_rd_cnt", stat_rd_cnt, 32'd3);
    chk("t6_wr_cnt", stat_wr_cnt, 32'd2);
    chk("t6_rd_cnt_model", stat_rd_cnt, rd_acc);
    chk("t6_wr_cnt_model", stat_wr_cnt, wr_acc);
    chk("t6_lat_max", stat_rd_lat_max, 16'd7);
    chk("t6_lat_max_model", stat_rd_lat_max, lat_max);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
